// File: rtl/ss_pkg.sv
// Shared definitions for the binary-to-BCD converter (ss_bin2bcd).
//   SS_DIGITS      : number of BCD digits driven to the scan driver
//   SS_MAX_DEC     : largest unsigned value that fits in eight digits
//   SS_MAX_NEG_MAG : largest negative magnitude that still leaves room for '-'
//   ss_digit_t     : one BCD digit / digit code
//   ss_state_e     : converter FSM states
package ss_pkg;

  localparam int          SS_DIGITS      = 8;
  localparam logic [31:0] SS_MAX_DEC     = 32'd99_999_999;
  localparam logic [31:0] SS_MAX_NEG_MAG = 32'd9_999_999;

  typedef logic [3:0] ss_digit_t;

  typedef enum logic [1:0] {
    SS_IDLE   = 2'd0,
    SS_SHIFT  = 2'd1,
    SS_COMMIT = 2'd2
  } ss_state_e;

endpackage

// File: rtl/ss_dd_nibble.sv
// Double-dabble correction for one BCD nibble: adds 3 when the nibble is 5 or
// more, so that the following left shift carries correctly into the next digit.
//   nib_i : current BCD nibble
//   nib_o : corrected nibble (before the shift)
module ss_dd_nibble
  import ss_pkg::*;
(
  input  ss_digit_t nib_i,
  output ss_digit_t nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? ss_digit_t'(nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/ss_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding an 8-digit seven-segment scan driver. Results are committed to
// shadow registers in one step, so the driver never sees a partial value.
// Optional build macro: SS_BCD_SIGNED_EN -- bin is two's complement and a
// minus sign (MINUS_CODE) is shown left of the most significant lit digit.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : conversion request, sampled only while idle
//   bin, blank_en     : value and leading-zero blanking, sampled on accept
//   busy              : conversion in progress
//   done              : one-cycle pulse when outputs have been updated
//   ovf               : last converted value was out of range
//   data7..data0      : BCD digits, data0 least significant
//   mask              : digit enables, bit i lights data i
module ss_bin2bcd
  import ss_pkg::*;
#(
  parameter int        WIDTH      = 27,
  parameter logic [3:0] MINUS_CODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  input  logic             blank_en,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       data7,
  output logic [3:0]       data6,
  output logic [3:0]       data5,
  output logic [3:0]       data4,
  output logic [3:0]       data3,
  output logic [3:0]       data2,
  output logic [3:0]       data1,
  output logic [3:0]       data0,
  output logic [7:0]       mask
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  ss_state_e        state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blank_q, blank_d;
  logic             neg_q, neg_d;
  logic             ovfp_q, ovfp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      dig_q, dig_d;
  logic [7:0]       mask_q, mask_d;

  logic [WIDTH-1:0] mag_w;
  logic             neg_w;
  logic [31:0]      mag32_w;
  logic             ovf_w;
  logic [31:0]      corr_w;
  logic [2:0]       msd_w;
  logic [2:0]       sign_idx_w;
  logic [7:0]       lz_mask_w;

`ifdef SS_BCD_SIGNED_EN
  assign neg_w = bin[WIDTH-1];
  assign mag_w = neg_w ? (~bin + 1'b1) : bin;
`else
  assign neg_w = 1'b0;
  assign mag_w = bin;
`endif

  // Range check on the loaded magnitude; a negative result needs one digit
  // for the sign, hence the smaller limit.
  assign mag32_w = 32'(mag_w);
  assign ovf_w   = neg_w ? (mag32_w > SS_MAX_NEG_MAG) : (mag32_w > SS_MAX_DEC);

  for (genvar g = 0; g < SS_DIGITS; g++) begin : g_nib
    ss_dd_nibble u_nib (
      .nib_i (acc_q[4*g +: 4]),
      .nib_o (corr_w[4*g +: 4])
    );
  end

  // Most significant non-zero digit of the finished accumulator (0 if all zero,
  // which keeps digit 0 lit) and the matching blanking mask.
  always_comb begin
    msd_w     = '0;
    lz_mask_w = '0;
    for (int i = 0; i < SS_DIGITS; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) msd_w = 3'(i);
    end
    for (int i = 0; i < SS_DIGITS; i++) begin
      lz_mask_w[i] = (3'(i) <= msd_w);
    end
  end

  // A negative magnitude has at most seven digits, so this never wraps.
  assign sign_idx_w = 3'(msd_w + 3'd1);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    neg_d   = neg_q;
    ovfp_d  = ovfp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    mask_d  = mask_q;
    case (state_q)
      SS_IDLE: begin
        if (start) begin
          state_d = SS_SHIFT;
          bin_d   = mag_w;
          acc_d   = '0;
          cnt_d   = '0;
          blank_d = blank_en;
          neg_d   = neg_w;
          ovfp_d  = ovf_w;
          busy_d  = 1'b1;
        end
      end
      SS_SHIFT: begin
        acc_d = (corr_w << 1) | 32'(bin_q[WIDTH-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = SS_COMMIT;
      end
      SS_COMMIT: begin
        state_d = SS_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = ovfp_q;
        if (ovfp_q) begin
          dig_d  = {SS_DIGITS{4'h9}};
          mask_d = 8'hFF;
        end else begin
          dig_d  = acc_q;
          mask_d = blank_q ? lz_mask_w : 8'hFF;
          if (neg_q) begin
            if (blank_q) begin
              dig_d[{sign_idx_w, 2'b00} +: 4] = MINUS_CODE;
              mask_d[sign_idx_w]              = 1'b1;
            end else begin
              dig_d[31:28] = MINUS_CODE;
            end
          end
        end
      end
      default: state_d = SS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SS_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      neg_q   <= 1'b0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
      mask_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      neg_q   <= neg_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      mask_q  <= mask_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign mask  = mask_q;
  assign data0 = dig_q[3:0];
  assign data1 = dig_q[7:4];
  assign data2 = dig_q[11:8];
  assign data3 = dig_q[15:12];
  assign data4 = dig_q[19:16];
  assign data5 = dig_q[23:20];
  assign data6 = dig_q[27:24];
  assign data7 = dig_q[31:28];

endmodule

// File: tb/tb_ss_bin2bcd.sv
// Directed bench for ss_bin2bcd (WIDTH=27). Digits are compared as one packed
// word {data7..data0}, so a BCD value reads directly as hex.
module tb_ss_bin2bcd;

  localparam int W = 27;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] bin = '0;
  logic         blank_en = 1'b0;
  logic         busy, done, ovf;
  logic [3:0]   d7, d6, d5, d4, d3, d2, d1, d0;
  logic [7:0]   mask;
  logic [31:0]  digits;

  int n_chk = 0;
  int n_err = 0;

  ss_bin2bcd #(.WIDTH(W), .MINUS_CODE(4'hF)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .blank_en (blank_en),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .data7    (d7),
    .data6    (d6),
    .data5    (d5),
    .data4    (d4),
    .data3    (d3),
    .data2    (d2),
    .data1    (d1),
    .data0    (d0),
    .mask     (mask)
  );

  assign digits = {d7, d6, d5, d4, d3, d2, d1, d0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Presents a request, lets it be accepted on the next edge and returns the
  // number of edges from the accepting edge until done is seen (capped at 60).
  task automatic convert(input logic [W-1:0] v, input logic b, output int lat);
    bin      = v;
    blank_en = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat, nd, at, gap;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_data", digits, 32'h0);
    chk("rst_mask", 32'(mask), 32'h01);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // 1: zero with blanking, latency WIDTH+1
    convert('0, 1'b1, lat);
    chk("zero_lat", 32'(lat), 32'd28);
    chk("zero_data", digits, 32'h0);
    chk("zero_mask", 32'(mask), 32'h01);
    chk("zero_ovf", 32'(ovf), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    tick(1);
    chk("done_pulse", 32'(done), 32'd0);

    // 2: 12345 blanked and unblanked
    convert(W'(12345), 1'b1, lat);
    chk("d12345_data", digits, 32'h00012345);
    chk("d12345_mask", 32'(mask), 32'h1F);
    convert(W'(12345), 1'b0, lat);
    chk("d12345_nb_data", digits, 32'h00012345);
    chk("d12345_nb_mask", 32'(mask), 32'hFF);

`ifndef SS_BCD_SIGNED_EN
    // 3: range limit and overflow
    convert(W'(99_999_999), 1'b1, lat);
    chk("max_data", digits, 32'h99999999);
    chk("max_mask", 32'(mask), 32'hFF);
    chk("max_ovf", 32'(ovf), 32'd0);
    convert(W'(100_000_000), 1'b1, lat);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_data", digits, 32'h99999999);
    chk("ovf_mask", 32'(mask), 32'hFF);
`endif
    convert(W'(7), 1'b1, lat);
    chk("seven_ovf", 32'(ovf), 32'd0);
    chk("seven_data", digits, 32'h00000007);
    chk("seven_mask", 32'(mask), 32'h01);

    // 4: start during conversion is ignored (new bin must not be picked up)
    bin = W'(1234); blank_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tick(4);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_hold", digits, 32'h00000007);
    bin = W'(9999); start = 1'b1;
    tick(10);
    start = 1'b0;
    nd = 0; at = 0;
    for (int i = 15; i <= 50; i++) begin
      @(posedge clk); #1;
      if (done) begin nd++; at = i; end
    end
    chk("ign_count", 32'(nd), 32'd1);
    chk("ign_lat", 32'(at), 32'd28);
    chk("ign_data", digits, 32'h00001234);
    chk("ign_mask", 32'(mask), 32'h0F);

    // Start held high: done, then accept on the following edge, then WIDTH+1
    // more edges, so pulses are WIDTH+2 edges apart.
    bin = W'(1234); start = 1'b1;
    lat = 0;
    @(posedge clk); #1;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("b2b_first_lat", 32'(lat), 32'd28);
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!done && gap < 60);
    start = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd29);
    tick(2);

    // 5: reset mid-conversion
    convert(W'(4321), 1'b1, lat);
    bin = W'(8765); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tick(10);
    rst = 1'b1; #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", digits, 32'h0);
    chk("arst_mask", 32'(mask), 32'h01);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("arst_nodone", 32'(nd), 32'd0);
    convert(W'(56), 1'b1, lat);
    chk("after_rst_lat", 32'(lat), 32'd28);
    chk("after_rst_data", digits, 32'h00000056);
    chk("after_rst_mask", 32'(mask), 32'h03);

`ifdef SS_BCD_SIGNED_EN
    // 6: signed values
    convert(-W'(42), 1'b1, lat);
    chk("neg42_data", digits, 32'h00000F42);
    chk("neg42_mask", 32'(mask), 32'h07);
    chk("neg42_ovf", 32'(ovf), 32'd0);
    convert(-W'(42), 1'b0, lat);
    chk("neg42_nb_data", digits, 32'hF0000042);
    chk("neg42_nb_mask", 32'(mask), 32'hFF);
    convert(-W'(10_000_000), 1'b1, lat);
    chk("negovf_flag", 32'(ovf), 32'd1);
    chk("negovf_data", digits, 32'h99999999);
    chk("negovf_mask", 32'(mask), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
